// File: rtl/aes_sched_pkg.sv
// Shared constants and tag-pipe entry type for the AES-128 pipeline scheduler.
// Used by aes_pipe_sched and aes_rr_arbiter.
package aes_sched_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int LATENCY_DEF = 10;

    // Tag field is sized for the widest supported configuration (NREQ <= 256).
    localparam int TAG_W = 8;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin grant selection: searches req upward from ptr with wrap-around,
// returning a one-hot grant and its index. Grants nothing while en is low.
module aes_rr_arbiter
    import aes_sched_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    // NOTE: every output gets a default before the search loop, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (en && !any && req[j]) begin
                any    = 1'b1;
                idx    = IDX_W'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_pipe_sched.sv
// Schedules NREQ requesters onto one pipelined AES-128 core and tracks
// ownership through a LATENCY-deep tag pipe. Optional: AES_SCHED_STATS_EN.
module aes_pipe_sched
    import aes_sched_pkg::*;
#(
    parameter  int NREQ    = NREQ_DEF,
    parameter  int LATENCY = LATENCY_DEF,
    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*128-1:0]  req_data,
    input  logic [NREQ*128-1:0]  req_key,
    output logic [127:0]         core_din,
    output logic [127:0]         core_key,
    output logic                 core_en,
    input  logic [127:0]         core_dout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDX_W-1:0]     rsp_tag,
    output logic [127:0]         rsp_data,
    output logic                 busy
`ifdef AES_SCHED_STATS_EN
    ,
    output logic [NREQ*32-1:0]   issue_cnt
`endif
);

    tag_entry_t       pipe [LATENCY];
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic             gnt_any;

    // A held response freezes the core, the tag pipe and the arbiter together.
    assign core_en = clr_n & ~(rsp_valid & ~rsp_ready);

    aes_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .en  (core_en),
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign req_ready = gnt;

    always_comb begin
        core_din = '0;
        core_key = '0;
        if (gnt_any) begin
            core_din = req_data[int'(gnt_idx)*128 +: 128];
            core_key = req_key[int'(gnt_idx)*128 +: 128];
        end
    end

    // NOTE: state registers use non-blocking assignments so the shift below
    // reads every stage's pre-edge value. The pipe is reset in full, not just
    // the valids, because it is tiny and a clean tag keeps rsp_tag at zero.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
            ptr <= '0;
        end else if (core_en) begin
            pipe[0].valid <= gnt_any;
            pipe[0].tag   <= TAG_W'(gnt_idx);
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
            if (gnt_any) ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign rsp_valid = pipe[LATENCY-1].valid;
    assign rsp_tag   = pipe[LATENCY-1].tag[IDX_W-1:0];
    assign rsp_data  = core_dout;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) busy = busy | pipe[i].valid;
    end

`ifdef AES_SCHED_STATS_EN
    logic [31:0] cnt [NREQ];

    // A grant is only ever issued to a valid requester, so it is the handshake.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (gnt[i]) cnt[i] <= cnt[i] + 32'd1;
        end
    end

    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < NREQ; i++) issue_cnt[32*i +: 32] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Directed bench for aes_pipe_sched with a behavioural pipelined AES-128 core.
// Define AES_SCHED_STATS_EN to also exercise the grant counters.
module tb_aes_pipe_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 10;

    logic                 clk = 1'b0;
    logic                 clr_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*128-1:0]  req_data;
    logic [NREQ*128-1:0]  req_key;
    logic [127:0]         core_din;
    logic [127:0]         core_key;
    logic                 core_en;
    logic [127:0]         core_dout;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_tag;
    logic [127:0]         rsp_data;
    logic                 busy;
`ifdef AES_SCHED_STATS_EN
    logic [NREQ*32-1:0]   issue_cnt;
`endif

    aes_pipe_sched #(.NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_key   (req_key),
        .core_din  (core_din),
        .core_key  (core_key),
        .core_en   (core_en),
        .core_dout (core_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef AES_SCHED_STATS_EN
        ,
        .issue_cnt (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference AES-128 ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] k128);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] k [16];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] ct;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            k[i] = k128[127-8*i -: 8];
            s[i] = s[i] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k[0] = k[0] ^ sbox[k[13]] ^ rc;
            k[1] = k[1] ^ sbox[k[14]];
            k[2] = k[2] ^ sbox[k[15]];
            k[3] = k[3] ^ sbox[k[12]];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row+4*col] = t[row + 4*((col + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
                    s[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    // ---------------- behavioural core: LAT stages, frozen by core_en ----------------
    logic [127:0] cstage [LAT];

    always @(posedge clk) begin
        if (core_en) begin
            cstage[0] <= aes128(core_din, core_key);
            for (int i = 1; i < LAT; i++) cstage[i] <= cstage[i-1];
        end
    end
    assign core_dout = cstage[LAT-1];

    // ---------------- requester operands ----------------
    logic [127:0] dat [NREQ];
    logic [127:0] key [NREQ];

    always_comb begin
        req_data = '0;
        req_key  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[128*i +: 128] = dat[i];
            req_key[128*i +: 128]  = key[i];
        end
    end

    // ---------------- scoreboard and checks ----------------
    typedef struct {
        logic [1:0]   tag;
        logic [127:0] data;
    } exp_t;

    exp_t sb [$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Checks any response handshake at the falling edge, then moves to posedge+1.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 128'(rsp_valid), 128'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_tag", 128'(rsp_tag), 128'(e.tag));
                chk("rsp_data", rsp_data, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Expect requester g (or none, g < 0) to be granted this cycle.
    task automatic step_grant(input int g);
        logic [NREQ-1:0] oh;
        #1;
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        chk("req_ready", 128'(req_ready), 128'(oh));
        if (g >= 0) begin
            chk("core_din", core_din, dat[g]);
            sb.push_back('{tag: 2'(g), data: aes128(dat[g], key[g])});
        end
        cycle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy === 1'b1 || sb.size() > 0) && n < 60) begin
            cycle();
            n++;
        end
        chk("drain_busy", 128'(busy), 128'd0);
        chk("drain_all_delivered", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        logic [NREQ*32-1:0] exp_cnt;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h01;
            for (int p = 0; p < 254; p++) inv = gm(inv, 8'(x));
            sbox[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
        end

        dat[0] = 128'h74657374746573747465737474657374;
        key[0] = 128'h6e6d6f73706d6f73636d6f73766c7369;
        dat[1] = 128'h00112233445566778899aabbccddeeff;
        key[1] = 128'h000102030405060708090a0b0c0d0e0f;
        dat[2] = 128'h3243f6a8885a308d313198a2e0370734;
        key[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        dat[3] = 128'hdeadbeefcafef00d0123456789abcdef;
        key[3] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

        // Reset state, with requests pending
        clr_n     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1 clr_n = 1'b0;
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_core_en", 128'(core_en), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_rsp_tag", 128'(rsp_tag), 128'd0);
        @(posedge clk);
        #1;

        // Single block on req0, accepted at the first edge after release
        clr_n     = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("core_key0", core_key, key[0]);
        step_grant(0);
        req_valid = 4'b0000;
        chk("busy_inflight", 128'(busy), 128'd1);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        chk("latency", 128'(n + 1), 128'd10);
        drain();

        // Three blocks in flight (ptr starts at 1), then reset mid-operation
        req_valid = 4'b0111;
        step_grant(1);
        step_grant(2);
        step_grant(0);
        req_valid = 4'hF;
        clr_n     = 1'b0;
        #1;
        chk("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_core_en", 128'(core_en), 128'd0);
        chk("midrst_req_ready", 128'(req_ready), 128'd0);
        sb.delete();
        cycle();
        cycle();

        // All four valid after release: 0,1,2,3,... one per cycle
        clr_n = 1'b1;
        g = 0;
        for (int i = 0; i < 12; i++) begin
            step_grant(g);
            g = (g + 1) % NREQ;
        end

        // Hold rsp_ready low for five cycles while a response is pending
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_core_en", 128'(core_en), 128'd0);
            chk("stall_req_ready", 128'(req_ready), 128'd0);
            chk("stall_rsp_valid", 128'(rsp_valid), 128'd1);
            chk("stall_rsp_tag", 128'(rsp_tag), 128'(sb[0].tag));
            chk("stall_rsp_data", rsp_data, sb[0].data);
            cycle();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_grant(g);
            g = (g + 1) % NREQ;
        end
        req_valid = 4'b0000;
        drain();

        // Wrap-around: req2 alone moves ptr to 3, then req2 alone again
        req_valid = 4'b0100;
        step_grant(2);
        step_grant(2);
        req_valid = 4'hF;
        step_grant(3);
        req_valid = 4'b0011;
        step_grant(0);
        req_valid = 4'b0000;
        #1;
        chk("bubble_req_ready", 128'(req_ready), 128'd0);
        chk("bubble_core_din", core_din, 128'd0);
        chk("bubble_core_key", core_key, 128'd0);
        cycle();
        drain();

`ifdef AES_SCHED_STATS_EN
        // Grant counters: seven handshakes on req1 only
        clr_n = 1'b0;
        #1;
        chk("cnt_after_rst", 128'(issue_cnt), 128'd0);
        sb.delete();
        cycle();
        clr_n     = 1'b1;
        req_valid = 4'b0010;
        for (int i = 0; i < 7; i++) step_grant(1);
        req_valid = 4'b0000;
        #1;
        exp_cnt = '0;
        exp_cnt[63:32] = 32'd7;
        chk("cnt_req1_seven", 128'(issue_cnt), 128'(exp_cnt));
        drain();
        clr_n = 1'b0;
        #1;
        chk("cnt_cleared", 128'(issue_cnt), 128'd0);
        cycle();
        clr_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
